// File: rtl/padding_layer_scheduler.sv
// Layer scheduler in front of a padding controller: queues layer configs, streams
// one layer's input beats through to the pad stage and tracks its write-back.
module padding_layer_scheduler #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [10:0]       cfg_ofm_c,
  input  logic [10:0]       cfg_ofm_w,
  input  logic              cfg_padding,
  input  logic              sched_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              pad_start,
  output logic              pad_valid,
  output logic [DATA_W-1:0] pad_data,
  output logic [10:0]       pad_ofm_c,
  output logic [10:0]       pad_ofm_w,
  output logic              pad_padding,
  input  logic              pad_wr_en,
  output logic              busy,
  output logic              layer_done,
  output logic [7:0]        layer_idx,
  output logic              cfg_full,
  output logic              cfg_overflow,
  output logic              timeout_err,
  output logic [2:0]        state_dbg
);
  // Handshake: a beat transfers on a rising edge where in_valid and in_ready are
  // both high; pad_valid mirrors that transfer in the same cycle with no latency.

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [22:0] fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty, push, pop;

  logic [10:0] head_c, head_w;
  logic        head_p;
  logic [31:0] c32, w32, wp32, total_data_nxt, total_wr_nxt;

  logic [31:0]   total_data, total_wr, data_cnt, wr_cnt;
  logic [TW-1:0] idle_cnt;
  logic          accept, data_last, wr_complete, timeout_hit;

  // FIFO: a pop in LOAD frees a slot in the same cycle, so a push while full is
  // still accepted when it coincides with the pop.
  assign fifo_empty = (fifo_cnt == '0);
  assign cfg_full   = (fifo_cnt == (AW+1)'(DEPTH));
  assign pop        = (state == LOAD);
  assign push       = cfg_wr && (!cfg_full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cfg_ofm_c, cfg_ofm_w, cfg_padding};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      cfg_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: ;
      endcase
      if (cfg_wr && cfg_full && !pop) cfg_overflow <= 1'b1;
    end
  end

  // Beat counts are 16-lane beats, so element counts are divided by 16 after
  // the full 32-bit product.
  assign {head_c, head_w, head_p} = fifo_mem[rd_ptr];
  assign c32            = {21'd0, head_c};
  assign w32            = {21'd0, head_w};
  assign wp32           = w32 + (head_p ? 32'd2 : 32'd0);
  assign total_data_nxt = (c32 * w32 * w32) >> 4;
  assign total_wr_nxt   = (c32 * wp32 * wp32) >> 4;

  assign accept      = in_valid && in_ready;
  assign data_last   = accept && (data_cnt + 32'd1 == total_data);
  assign wr_complete = (wr_cnt == total_wr) || (pad_wr_en && (wr_cnt + 32'd1 == total_wr));
  assign timeout_hit = !pad_wr_en && (idle_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sched_en && !fifo_empty) state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if ((data_cnt >= total_data) || data_last) state_nxt = DRAIN;
      DRAIN: begin
        if (wr_complete)      state_nxt = DONE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == RUN) && (data_cnt < total_data);
    pad_valid  = in_valid && in_ready;
    pad_data   = (state == RUN) ? in_data : '0;
    pad_start  = (state == START);
    layer_done = (state == DONE);
    busy       = (state != IDLE);
    state_dbg  = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_ofm_c   <= '0;
      pad_ofm_w   <= '0;
      pad_padding <= 1'b0;
      total_data  <= '0;
      total_wr    <= '0;
    end else if (state == LOAD) begin
      pad_ofm_c   <= head_c;
      pad_ofm_w   <= head_w;
      pad_padding <= head_p;
      total_data  <= total_data_nxt;
      total_wr    <= total_wr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_cnt    <= '0;
      wr_cnt      <= '0;
      idle_cnt    <= '0;
      layer_idx   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == START) begin
        data_cnt <= '0;
        wr_cnt   <= '0;
      end else begin
        if (accept) data_cnt <= data_cnt + 32'd1;
        if ((state == RUN || state == DRAIN) && pad_wr_en && (wr_cnt != total_wr))
          wr_cnt <= wr_cnt + 32'd1;
      end
      // Idle run length only matters while waiting for write-back.
      if (state == DRAIN && !pad_wr_en) idle_cnt <= idle_cnt + TW'(1);
      else                              idle_cnt <= '0;
      if (state == DRAIN && !wr_complete && timeout_hit) timeout_err <= 1'b1;
      if (state == DONE) layer_idx <= layer_idx + 8'd1;
    end
  end

endmodule

// File: tb/tb_padding_layer_scheduler.sv
// Self-checking bench for padding_layer_scheduler: scenario tasks plus a data
// scoreboard filled by the beat driver and drained by a negedge monitor.
module tb_padding_layer_scheduler;
  localparam int DATA_W  = 128;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_wr = 1'b0;
  logic [10:0]       cfg_ofm_c = '0;
  logic [10:0]       cfg_ofm_w = '0;
  logic              cfg_padding = 1'b0;
  logic              sched_en = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, pad_start, pad_valid;
  logic [DATA_W-1:0] pad_data;
  logic [10:0]       pad_ofm_c, pad_ofm_w;
  logic              pad_padding;
  logic              pad_wr_en = 1'b0;
  logic              busy, layer_done, cfg_full, cfg_overflow, timeout_err;
  logic [7:0]        layer_idx;
  logic [2:0]        state_dbg;

  padding_layer_scheduler #(.DEPTH(4), .DATA_W(DATA_W), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ofm_c(cfg_ofm_c), .cfg_ofm_w(cfg_ofm_w),
    .cfg_padding(cfg_padding), .sched_en(sched_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pad_start(pad_start), .pad_valid(pad_valid), .pad_data(pad_data),
    .pad_ofm_c(pad_ofm_c), .pad_ofm_w(pad_ofm_w), .pad_padding(pad_padding),
    .pad_wr_en(pad_wr_en), .busy(busy), .layer_done(layer_done), .layer_idx(layer_idx),
    .cfg_full(cfg_full), .cfg_overflow(cfg_overflow), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int start_cyc = 0;
  int push_cyc = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_d;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (pad_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (layer_done) done_cnt++;
    if (pad_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_data: got beat %h, expected none (queue empty)", pad_data);
      end else begin
        exp_d = exp_q.pop_front();
        if (pad_data !== exp_d) begin
          errors++;
          $display("FAIL sb_data: got %h, expected %h", pad_data, exp_d);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cfg_wr = 1'b0; sched_en = 1'b0; in_valid = 1'b0; pad_wr_en = 1'b0;
    step();
    step();
    exp_q.delete();
    rst = 1'b0;
    step();
  endtask

  task automatic push_cfg(input int c, input int w, input int p);
    cfg_ofm_c = 11'(c);
    cfg_ofm_w = 11'(w);
    cfg_padding = p[0];
    cfg_wr = 1'b1;
    step();
    push_cyc = cyc;
    cfg_wr = 1'b0;
  endtask

  function automatic int exp_beats(input int c, input int w);
    return (c * w * w) / 16;
  endfunction

  task automatic stream_beats(input int n, output int sent, output logic [22:0] seen);
    int guard = 0;
    sent = 0;
    seen = '0;
    while (sent < n && guard < 400) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
      end else begin
        in_valid = 1'b1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        #1;
        if (in_ready) begin
          if (sent == 0) seen = {pad_ofm_c, pad_ofm_w, pad_padding};
          exp_q.push_back(in_data);
          sent++;
        end
        step();
      end
      guard++;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_writes(input int n);
    for (int i = 0; i < n; i++) begin
      pad_wr_en = 1'b1;
      step();
    end
    pad_wr_en = 1'b0;
  endtask

  task automatic run_layer(input int c, input int w, input int p, output int beats,
                           output logic [22:0] seen, output bit dropped, output bit done_ok);
    int prev = done_cnt;
    int g = 0;
    int wp = w + 2 * p;
    stream_beats(exp_beats(c, w), beats, seen);
    in_valid = 1'b1;
    #1;
    dropped = (in_ready === 1'b0) && (pad_valid === 1'b0);
    in_valid = 1'b0;
    send_writes(exp_beats(c, wp));
    while (done_cnt == prev && g < 20) begin
      step();
      g++;
    end
    done_ok = (done_cnt == prev + 1);
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_data = {4{32'hA5A5_5A5A}}; pad_wr_en = 1'b1; sched_en = 1'b1;
    step();
    step();
    checks++;
    if ({in_ready, pad_start, pad_valid, busy, layer_done, cfg_full, cfg_overflow, timeout_err,
         pad_padding, pad_ofm_c, pad_ofm_w, layer_idx} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b in_ready=%b full=%b idx=%0d c=%0d, expected all 0",
               busy, in_ready, cfg_full, layer_idx, pad_ofm_c);
    end
    checks++;
    if (pad_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h, expected 0", pad_data);
    end
    apply_reset();
    checks++;
    if (state_dbg !== S_IDLE || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got state=%0d busy=%b, expected 0/0", state_dbg, busy);
    end
  endtask

  task automatic test_basic();
    int beats, s0, d0, pc;
    logic [22:0] seen;
    bit dropped, done_ok;
    apply_reset();
    sched_en = 1'b1;
    s0 = start_cnt; d0 = done_cnt;
    push_cfg(16, 4, 1);
    pc = push_cyc;
    run_layer(16, 4, 1, beats, seen, dropped, done_ok);
    checks++;
    if (beats != 16) begin errors++; $display("FAIL basic_beats: got %0d, expected 16", beats); end
    checks++;
    if (seen !== {11'd16, 11'd4, 1'b1}) begin
      errors++; $display("FAIL basic_cfg: got %h, expected %h", seen, {11'd16, 11'd4, 1'b1});
    end
    checks++;
    if (!dropped) begin errors++; $display("FAIL basic_ready_drop: got in_ready=%b, expected 0", in_ready); end
    checks++;
    if (!done_ok || done_cnt - d0 != 1 || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL basic_pulses: got starts=%0d dones=%0d, expected 1/1", start_cnt - s0, done_cnt - d0);
    end
    checks++;
    if (start_cyc - pc < 2) begin
      errors++; $display("FAIL basic_start_latency: got %0d cycles, expected >= 2", start_cyc - pc);
    end
    checks++;
    if (layer_idx !== 8'd1 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: got idx=%0d busy=%b terr=%b, expected 1/0/0", layer_idx, busy, timeout_err);
    end
  endtask

  task automatic test_back_to_back();
    int b0, b1, s0, d0;
    logic [22:0] seen0, seen1;
    bit dr0, dr1, ok0, ok1;
    apply_reset();
    sched_en = 1'b1;
    s0 = start_cnt; d0 = done_cnt;
    push_cfg(32, 2, 0);
    push_cfg(16, 4, 1);
    run_layer(32, 2, 0, b0, seen0, dr0, ok0);
    run_layer(16, 4, 1, b1, seen1, dr1, ok1);
    checks++;
    if (b0 != 8 || b1 != 16) begin
      errors++; $display("FAIL b2b_beats: got %0d/%0d, expected 8/16", b0, b1);
    end
    checks++;
    if (seen0 !== {11'd32, 11'd2, 1'b0} || seen1 !== {11'd16, 11'd4, 1'b1}) begin
      errors++; $display("FAIL b2b_cfg: got %h/%h, expected %h/%h", seen0, seen1,
                         {11'd32, 11'd2, 1'b0}, {11'd16, 11'd4, 1'b1});
    end
    checks++;
    if (!dr0 || !dr1 || !ok0 || !ok1) begin
      errors++; $display("FAIL b2b_flow: got drop=%b%b done=%b%b, expected 11/11", dr0, dr1, ok0, ok1);
    end
    checks++;
    if (start_cnt - s0 != 2 || done_cnt - d0 != 2 || layer_idx !== 8'd2) begin
      errors++;
      $display("FAIL b2b_counts: got starts=%0d dones=%0d idx=%0d, expected 2/2/2",
               start_cnt - s0, done_cnt - d0, layer_idx);
    end
  endtask

  task automatic test_overflow();
    int beats, s0;
    logic [22:0] seen;
    bit dropped, done_ok;
    apply_reset();
    for (int i = 1; i <= 3; i++) push_cfg(16 * i, 1, 0);
    checks++;
    if (cfg_full !== 1'b0) begin errors++; $display("FAIL ovf_not_full: got %b, expected 0", cfg_full); end
    push_cfg(64, 1, 0);
    checks++;
    if (cfg_full !== 1'b1 || cfg_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_full: got full=%b ovf=%b, expected 1/0", cfg_full, cfg_overflow);
    end
    push_cfg(80, 1, 0);
    checks++;
    if (cfg_overflow !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ovf_set: got ovf=%b busy=%b, expected 1/0", cfg_overflow, busy);
    end
    s0 = start_cnt;
    sched_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      run_layer(16 * i, 1, 0, beats, seen, dropped, done_ok);
      checks++;
      if (seen !== {11'(16 * i), 11'd1, 1'b0} || beats != i || !done_ok) begin
        errors++;
        $display("FAIL ovf_layer%0d: got cfg=%h beats=%0d done=%b, expected %h/%0d/1",
                 i, seen, beats, done_ok, {11'(16 * i), 11'd1, 1'b0}, i);
      end
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (busy !== 1'b0 || start_cnt - s0 != 4 || cfg_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_dropped: got busy=%b starts=%0d ovf=%b, expected 0/4/1", busy, start_cnt - s0, cfg_overflow);
    end
  endtask

  task automatic test_push_pop_full();
    int beats;
    logic [22:0] seen;
    bit dropped, done_ok;
    apply_reset();
    for (int i = 1; i <= 4; i++) push_cfg(16 * i, 1, 0);
    sched_en = 1'b1;
    step();
    checks++;
    if (state_dbg !== S_LOAD || cfg_full !== 1'b1) begin
      errors++; $display("FAIL ppf_load: got state=%0d full=%b, expected %0d/1", state_dbg, cfg_full, S_LOAD);
    end
    push_cfg(80, 1, 0);
    checks++;
    if (cfg_overflow !== 1'b0 || cfg_full !== 1'b1) begin
      errors++; $display("FAIL ppf_accept: got ovf=%b full=%b, expected 0/1", cfg_overflow, cfg_full);
    end
    for (int i = 1; i <= 5; i++) begin
      run_layer(16 * i, 1, 0, beats, seen, dropped, done_ok);
      checks++;
      if (seen !== {11'(16 * i), 11'd1, 1'b0} || !done_ok) begin
        errors++;
        $display("FAIL ppf_layer%0d: got cfg=%h done=%b, expected %h/1", i, seen, done_ok, {11'(16 * i), 11'd1, 1'b0});
      end
    end
    checks++;
    if (layer_idx !== 8'd5) begin errors++; $display("FAIL ppf_idx: got %0d, expected 5", layer_idx); end
  endtask

  task automatic test_timeout();
    int sent, d0;
    logic [22:0] seen;
    apply_reset();
    sched_en = 1'b1;
    d0 = done_cnt;
    push_cfg(16, 4, 1);
    stream_beats(16, sent, seen);
    send_writes(20);
    for (int i = 0; i < 1023; i++) step();
    checks++;
    if (sent != 16 || timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_early: got sent=%0d terr=%b busy=%b, expected 16/0/1", sent, timeout_err, busy);
    end
    step();
    checks++;
    if (timeout_err !== 1'b1 || state_dbg !== S_IDLE || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_fire: got terr=%b state=%0d busy=%b, expected 1/0/0", timeout_err, state_dbg, busy);
    end
    checks++;
    if (done_cnt != d0 || layer_idx !== 8'd0) begin
      errors++; $display("FAIL to_no_done: got dones=%0d idx=%0d, expected 0/0", done_cnt - d0, layer_idx);
    end
  endtask

  task automatic test_reset_mid_run();
    int beats, sent, s0, d0;
    logic [22:0] seen;
    bit dropped, done_ok;
    apply_reset();
    sched_en = 1'b1;
    push_cfg(16, 1, 0);
    push_cfg(16, 4, 1);
    push_cfg(32, 2, 0);
    run_layer(16, 1, 0, beats, seen, dropped, done_ok);
    stream_beats(7, sent, seen);
    in_valid = 1'b1;
    #1;
    checks++;
    if (sent != 7 || in_ready !== 1'b1 || layer_idx !== 8'd1) begin
      errors++;
      $display("FAIL rst_pre: got sent=%0d in_ready=%b idx=%0d, expected 7/1/1", sent, in_ready, layer_idx);
    end
    s0 = start_cnt; d0 = done_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || pad_valid !== 1'b0 || layer_idx !== 8'd0) begin
      errors++;
      $display("FAIL rst_async: got busy=%b in_ready=%b pad_valid=%b idx=%0d, expected 0/0/0/0",
               busy, in_ready, pad_valid, layer_idx);
    end
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (busy !== 1'b0 || cfg_full !== 1'b0 || start_cnt != s0 || done_cnt != d0) begin
      errors++;
      $display("FAIL rst_after: got busy=%b full=%b starts=%0d dones=%0d, expected 0/0/0/0",
               busy, cfg_full, start_cnt - s0, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_push_pop_full();
    test_timeout();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending beats, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/padding_layer_scheduler.md
PADDING_LAYER_SCHEDULER -- requirements
Module: padding_layer_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of layer-config queue entries (power of 2).
REQ-002 SHALL have parameter DATA_W, default 128, meaning data beat width (16 lanes x 8 bit).
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning idle cycles without pad_wr_en tolerated in DRAIN.
REQ-004 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports cfg_wr (in, 1, push strobe), cfg_ofm_c (in, 11, channels, multiple of 16), cfg_ofm_w (in, 11, square width), cfg_padding (in, 1, 1 = pad one pixel each side).
REQ-007 SHALL have ports sched_en (in, 1, allow new layers); in_valid (in, 1); in_data (in, DATA_W); in_ready (out, 1).
REQ-008 SHALL have ports pad_start (out, 1); pad_valid (out, 1); pad_data (out, DATA_W); pad_ofm_c (out, 11); pad_ofm_w (out, 11); pad_padding (out, 1); pad_wr_en (in, 1, write strobe from padding controller).
REQ-009 SHALL have outputs busy (1), layer_done (1), layer_idx (8), cfg_full (1), cfg_overflow (1, sticky), timeout_err (1, sticky).

Function
REQ-010 SHALL hold configs in a DEPTH-entry FIFO; cfg_wr while full and not popping SHALL drop the entry and set cfg_overflow.
REQ-011 SHALL, on simultaneous push and pop when full, pop first and accept the push.
REQ-012 SHALL implement states IDLE, LOAD, START, RUN, DRAIN, DONE.
REQ-013 IDLE -> LOAD when sched_en=1 and FIFO non-empty; otherwise stay.
REQ-014 LOAD SHALL pop one entry into active registers driving pad_ofm_c/pad_ofm_w/pad_padding, held stable until the next LOAD.
REQ-015 LOAD SHALL register total_data = (C*W*W)>>4 and total_wr = (C*(W+2p)*(W+2p))>>4 as 32-bit unsigned; products computed at 32 bits, no truncation before the shift.
REQ-016 START SHALL assert pad_start for exactly one cycle, clear data_cnt and wr_cnt, then -> RUN.
REQ-017 RUN: in_ready = 1 while data_cnt < total_data; pad_valid = in_valid & in_ready; pad_data = in_data combinationally (zero latency); data_cnt increments per accepted beat.
REQ-018 RUN -> DRAIN in the cycle after the accepted beat that makes data_cnt = total_data.
REQ-019 wr_cnt SHALL increment on every pad_wr_en=1 in RUN and DRAIN, saturating at total_wr.
REQ-020 DRAIN -> DONE when wr_cnt = total_wr (including the cycle whose pad_wr_en completes it).
REQ-021 DRAIN SHALL count consecutive cycles without pad_wr_en; reaching TIMEOUT SHALL set timeout_err and -> IDLE without layer_done.
REQ-022 DONE SHALL assert layer_done one cycle, increment layer_idx (wraps 255 -> 0), -> IDLE.
REQ-023 in_ready and pad_valid SHALL be 0 in all states except RUN.
REQ-024 busy = 1 in every state except IDLE.
REQ-025 sched_en deassertion SHALL only block IDLE -> LOAD; an active layer completes.
REQ-026 A config with total_data = 0 SHALL pass RUN in one cycle with in_ready=0.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, empty FIFO, clear counters, layer_idx, cfg_overflow, timeout_err, active config.
REQ-028 During reset all outputs SHALL be 0 (cfg_full=0); reset mid-layer SHALL abandon it without pad_start or layer_done.
REQ-029 First pad_start after reset release SHALL occur no earlier than 2 cycles after the first cfg_wr.

Verification
REQ-030 Push C=16,W=4,p=1, sched_en=1, stream 16 beats, return 36 pad_wr_en -> one pad_start, in_ready drops after beat 16, one layer_done, layer_idx=1.
REQ-031 Push C=32,W=2,p=0 then C=16,W=4,p=1 back-to-back -> layer 0 takes 8 beats/8 writes, layer 1 16/36, two pad_start pulses, layer_idx=2.
REQ-032 Push 5 configs with sched_en=0, DEPTH=4 -> cfg_full=1 after 4, fifth dropped, cfg_overflow=1.
REQ-033 Complete data for C=16,W=4,p=1, stop pad_wr_en at 20 writes -> timeout_err=1 after 1024 idle cycles, state IDLE, no layer_done.
REQ-034 Assert rst mid-RUN after 7 beats -> busy=0, in_ready=0, layer_idx=0 immediately; FIFO empty after release.
REQ-035 Full FIFO with push coincident with LOAD pop -> push accepted, cfg_overflow stays 0.
